// File: rtl/controlador_rodadas.sv
// Round sequencer: latches a target, waits for the player (with timeout), pulses the grader and
// accumulates a saturating score. Optional BONUS_PERFEITO_EN makes a grade of 10 score 12.
module controlador_rodadas #(
  parameter int unsigned N_RODADAS = 4,
  parameter int unsigned T_ESPERA  = 8,
  parameter int unsigned W_TOTAL   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               jogada,
  input  logic [3:0]         ideal_in,
  input  logic [3:0]         sensor_in,
  input  logic [3:0]         nota_in,
  output logic [3:0]         ideal_out,
  output logic [3:0]         sensor_out,
  output logic               avalia,
  output logic [3:0]         rodada,
  output logic [W_TOTAL-1:0] total,
  output logic               tempo_esgotado,
  output logic               ocupado,
  output logic               pronto
);

  localparam int unsigned TW = (T_ESPERA > 1) ? $clog2(T_ESPERA) : 1;
  // Sum width leaves headroom for the largest per-round score (12) plus a carry bit.
  localparam int unsigned SW = ((W_TOTAL > 4) ? W_TOTAL : 4) + 1;

  typedef enum logic [2:0] {
    StOcioso, StPrepara, StEspera, StAvalia, StAcumula, StFim
  } estado_e;

  estado_e            estado_q, estado_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [3:0]         ideal_q, ideal_d, sensor_q, sensor_d, rodada_q, rodada_d;
  logic [W_TOTAL-1:0] total_q, total_d;
  logic               esgotado_q, esgotado_d, avalia_q, avalia_d;
  logic               ocupado_q, ocupado_d, pronto_q, pronto_d;
  logic [3:0]         pts;
  logic [SW-1:0]      soma;

  // esgotado_q is high exactly in the ACUMULA cycle of a timed-out round.
  always_comb begin
    pts = 4'd0;
    if (!esgotado_q && (nota_in >= 4'd1) && (nota_in <= 4'd10)) begin
`ifdef BONUS_PERFEITO_EN
      pts = (nota_in == 4'd10) ? 4'd12 : nota_in;
`else
      pts = nota_in;
`endif
    end
    soma = SW'(total_q) + SW'(pts);
  end

  always_comb begin
    estado_d   = estado_q;
    timer_d    = timer_q;
    ideal_d    = ideal_q;
    sensor_d   = sensor_q;
    rodada_d   = rodada_q;
    total_d    = total_q;
    esgotado_d = 1'b0;
    case (estado_q)
      StOcioso, StFim: begin
        if (iniciar) begin
          estado_d = StPrepara;
          total_d  = '0;
          rodada_d = 4'd1;
        end
      end
      StPrepara: begin
        ideal_d  = ideal_in;
        timer_d  = '0;
        estado_d = StEspera;
      end
      StEspera: begin
        if (jogada) begin
          sensor_d = sensor_in;
          estado_d = StAvalia;
        end else if (timer_q == TW'(T_ESPERA - 1)) begin
          esgotado_d = 1'b1;
          estado_d   = StAcumula;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StAvalia: estado_d = StAcumula;
      StAcumula: begin
        total_d = (|soma[SW-1:W_TOTAL]) ? '1 : soma[W_TOTAL-1:0];
        if (rodada_q == 4'(N_RODADAS)) begin
          estado_d = StFim;
        end else begin
          rodada_d = rodada_q + 4'd1;
          estado_d = StPrepara;
        end
      end
      default: estado_d = StOcioso;
    endcase
    avalia_d  = (estado_d == StAvalia);
    ocupado_d = (estado_d != StOcioso) && (estado_d != StFim);
    pronto_d  = (estado_d == StFim);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= StOcioso;
      timer_q    <= '0;
      ideal_q    <= '0;
      sensor_q   <= '0;
      rodada_q   <= '0;
      total_q    <= '0;
      esgotado_q <= 1'b0;
      avalia_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      timer_q    <= timer_d;
      ideal_q    <= ideal_d;
      sensor_q   <= sensor_d;
      rodada_q   <= rodada_d;
      total_q    <= total_d;
      esgotado_q <= esgotado_d;
      avalia_q   <= avalia_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
    end
  end

  assign ideal_out      = ideal_q;
  assign sensor_out     = sensor_q;
  assign avalia         = avalia_q;
  assign rodada         = rodada_q;
  assign total          = total_q;
  assign tempo_esgotado = esgotado_q;
  assign ocupado        = ocupado_q;
  assign pronto         = pronto_q;

endmodule

// File: tb/tb_controlador_rodadas.sv
// Randomized bench for controlador_rodadas: an 8-bit and a 5-bit (saturating) instance share
// stimulus; expected scores come from per-round arithmetic in the bench.
module tb_controlador_rodadas;

  localparam int unsigned NR = 4;
  localparam int unsigned TE = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic [3:0] ideal_in = '0, sensor_in = '0, nota_in = '0;

  logic [3:0] ideal_out, sensor_out, rodada;
  logic [7:0] total;
  logic       avalia, tempo_esgotado, ocupado, pronto;

  logic [3:0] s_ideal_out, s_sensor_out, s_rodada;
  logic [4:0] s_total;
  logic       s_avalia, s_tempo_esgotado, s_ocupado, s_pronto;

  int n_cmp = 0;
  int n_err = 0;
  int exp_total, exp_total_s, exp_rodada;

  controlador_rodadas #(.N_RODADAS(NR), .T_ESPERA(TE), .W_TOTAL(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .ideal_in(ideal_in), .sensor_in(sensor_in), .nota_in(nota_in),
    .ideal_out(ideal_out), .sensor_out(sensor_out), .avalia(avalia), .rodada(rodada),
    .total(total), .tempo_esgotado(tempo_esgotado), .ocupado(ocupado), .pronto(pronto)
  );

  controlador_rodadas #(.N_RODADAS(NR), .T_ESPERA(TE), .W_TOTAL(5)) dut_sat (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .ideal_in(ideal_in), .sensor_in(sensor_in), .nota_in(nota_in),
    .ideal_out(s_ideal_out), .sensor_out(s_sensor_out), .avalia(s_avalia), .rodada(s_rodada),
    .total(s_total), .tempo_esgotado(s_tempo_esgotado), .ocupado(s_ocupado), .pronto(s_pronto)
  );

  always #5 clock = ~clock;

  function automatic int pontos(input logic [3:0] n);
    if (n >= 4'd1 && n <= 4'd10) begin
`ifdef BONUS_PERFEITO_EN
      if (n == 4'd10) return 12;
`endif
      return int'(n);
    end
    return 0;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_game;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    exp_total = 0;
    exp_total_s = 0;
    exp_rodada = 1;
    n_cmp++;
    if (total !== 8'd0 || s_total !== 5'd0 || rodada !== 4'd1 || ocupado !== 1'b1 ||
        pronto !== 1'b0) begin
      n_err++;
      $display("FAIL start: total=%0d s_total=%0d rodada=%0d ocupado=%b pronto=%b, required 0 0 1 1 0",
               total, s_total, rodada, ocupado, pronto);
    end
  endtask

  // Entered with the DUT in PREPARA; w < 0 means the player never confirms.
  task automatic play_round(input int w, input logic [3:0] id, input logic [3:0] sn,
                            input logic [3:0] nt);
    ideal_in = id;
    tick();
    ideal_in = 4'($urandom);
    n_cmp++;
    if (ideal_out !== id || ocupado !== 1'b1) begin
      n_err++;
      $display("FAIL ideal_latch: ideal_out=%0d ocupado=%b, required %0d 1", ideal_out, ocupado, id);
    end
    if (w < 0) begin
      for (int k = 1; k <= int'(TE); k++) begin
        iniciar = 1'($urandom);
        tick();
        if (k < int'(TE)) begin
          n_cmp++;
          if (tempo_esgotado !== 1'b0 || avalia !== 1'b0) begin
            n_err++;
            $display("FAIL early_timeout k=%0d: tempo_esgotado=%b avalia=%b, required 0 0",
                     k, tempo_esgotado, avalia);
          end
        end
      end
      n_cmp++;
      if (tempo_esgotado !== 1'b1 || avalia !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_pulse: tempo_esgotado=%b avalia=%b, required 1 0",
                 tempo_esgotado, avalia);
      end
      iniciar = 1'b0;
      nota_in = 4'($urandom_range(1, 10));
      tick();
      n_cmp++;
      if (tempo_esgotado !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_width: tempo_esgotado=%b, required 0", tempo_esgotado);
      end
    end else begin
      for (int k = 0; k < w; k++) begin
        iniciar = 1'($urandom);
        tick();
        n_cmp++;
        if (tempo_esgotado !== 1'b0 || avalia !== 1'b0) begin
          n_err++;
          $display("FAIL waiting k=%0d: tempo_esgotado=%b avalia=%b, required 0 0",
                   k, tempo_esgotado, avalia);
        end
      end
      iniciar = 1'b0;
      jogada = 1'b1;
      sensor_in = sn;
      tick();
      jogada = 1'b0;
      sensor_in = 4'($urandom);
      n_cmp++;
      if (avalia !== 1'b1 || sensor_out !== sn || ideal_out !== id || tempo_esgotado !== 1'b0) begin
        n_err++;
        $display("FAIL avalia: avalia=%b sensor_out=%0d ideal_out=%0d tempo_esgotado=%b, required 1 %0d %0d 0",
                 avalia, sensor_out, ideal_out, tempo_esgotado, sn, id);
      end
      jogada = 1'($urandom);
      iniciar = 1'($urandom);
      tick();
      jogada = 1'b0;
      iniciar = 1'b0;
      n_cmp++;
      if (avalia !== 1'b0 || sensor_out !== sn || ideal_out !== id) begin
        n_err++;
        $display("FAIL acumula: avalia=%b sensor_out=%0d ideal_out=%0d, required 0 %0d %0d",
                 avalia, sensor_out, ideal_out, sn, id);
      end
      nota_in = nt;
      tick();
      exp_total = sat(exp_total + pontos(nt), 255);
      exp_total_s = sat(exp_total_s + pontos(nt), 31);
    end
    n_cmp++;
    if (total !== 8'(exp_total) || s_total !== 5'(exp_total_s)) begin
      n_err++;
      $display("FAIL total: total=%0d s_total=%0d, required %0d %0d",
               total, s_total, exp_total, exp_total_s);
    end
    if (exp_rodada == int'(NR)) begin
      n_cmp++;
      if (pronto !== 1'b1 || ocupado !== 1'b0 || rodada !== 4'(NR)) begin
        n_err++;
        $display("FAIL fim: pronto=%b ocupado=%b rodada=%0d, required 1 0 %0d",
                 pronto, ocupado, rodada, NR);
      end
    end else begin
      exp_rodada++;
      n_cmp++;
      if (pronto !== 1'b0 || ocupado !== 1'b1 || rodada !== 4'(exp_rodada)) begin
        n_err++;
        $display("FAIL next_round: pronto=%b ocupado=%b rodada=%0d, required 0 1 %0d",
                 pronto, ocupado, rodada, exp_rodada);
      end
    end
  endtask

  task automatic random_round;
    int w;
    w = int'($urandom_range(0, 9));
    if (w >= int'(TE)) w = -1;
    play_round(w, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    tick();
    n_cmp++;
    if (total !== 8'd0 || rodada !== 4'd0 || ocupado !== 1'b0 || pronto !== 1'b0 ||
        avalia !== 1'b0 || tempo_esgotado !== 1'b0 || ideal_out !== 4'd0 || sensor_out !== 4'd0) begin
      n_err++;
      $display("FAIL reset: total=%0d rodada=%0d ocupado=%b pronto=%b avalia=%b, required all 0",
               total, rodada, ocupado, pronto, avalia);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ocupado !== 1'b0 || rodada !== 4'd0) begin
      n_err++;
      $display("FAIL idle: ocupado=%b rodada=%0d, required 0 0", ocupado, rodada);
    end
  endtask

  task automatic test_perfect_game;
    start_game();
    for (int r = 0; r < int'(NR); r++) play_round(int'($urandom_range(0, TE - 1)), 4'd5, 4'd5, 4'd10);
    n_cmp++;
`ifdef BONUS_PERFEITO_EN
    if (total !== 8'd48 || s_total !== 5'd31) begin
      n_err++;
      $display("FAIL perfect_game: total=%0d s_total=%0d, required 48 31", total, s_total);
    end
`else
    if (total !== 8'd40 || s_total !== 5'd31) begin
      n_err++;
      $display("FAIL perfect_game: total=%0d s_total=%0d, required 40 31", total, s_total);
    end
`endif
  endtask

  task automatic test_fim_hold;
    for (int k = 0; k < 5; k++) begin
      jogada = 1'($urandom);
      nota_in = 4'($urandom);
      tick();
      n_cmp++;
      if (total !== 8'(exp_total) || pronto !== 1'b1 || avalia !== 1'b0 || rodada !== 4'(NR)) begin
        n_err++;
        $display("FAIL fim_hold: total=%0d pronto=%b avalia=%b rodada=%0d, required %0d 1 0 %0d",
                 total, pronto, avalia, rodada, exp_total, NR);
      end
    end
    jogada = 1'b0;
  endtask

  task automatic test_timeout;
    start_game();
    play_round(-1, 4'd3, 4'd3, 4'd10);
    for (int r = 1; r < int'(NR); r++) random_round();
  endtask

  task automatic test_nota_range;
    start_game();
    play_round(2, 4'd1, 4'd2, 4'd11);
    play_round(0, 4'd4, 4'd4, 4'd0);
    play_round(5, 4'd9, 4'd8, 4'd7);
    play_round(1, 4'd6, 4'd6, 4'd15);
  endtask

  task automatic test_deadline;
    start_game();
    for (int r = 0; r < int'(NR); r++)
      play_round(int'(TE) - 1, 4'($urandom), 4'($urandom), 4'($urandom_range(1, 10)));
  endtask

  task automatic test_random_games;
    for (int g = 0; g < 6; g++) begin
      start_game();
      for (int r = 0; r < int'(NR); r++) random_round();
    end
  endtask

  task automatic test_reset_mid_game;
    start_game();
    random_round();
    ideal_in = 4'd7;
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (total !== 8'd0 || s_total !== 5'd0 || rodada !== 4'd0 || ocupado !== 1'b0 ||
        pronto !== 1'b0 || ideal_out !== 4'd0) begin
      n_err++;
      $display("FAIL reset_mid: total=%0d rodada=%0d ocupado=%b pronto=%b ideal_out=%0d, required 0 0 0 0 0",
               total, rodada, ocupado, pronto, ideal_out);
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ocupado !== 1'b0 || total !== 8'd0) begin
      n_err++;
      $display("FAIL after_reset: ocupado=%b total=%0d, required 0 0", ocupado, total);
    end
    start_game();
    for (int r = 0; r < int'(NR); r++) random_round();
  endtask

  initial begin
    test_reset();
    test_perfect_game();
    test_fim_hold();
    test_timeout();
    test_nota_range();
    test_deadline();
    test_random_games();
    test_reset_mid_game();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
